// File: rtl/vad_pkg.sv
// Shared types and constants for the voice-activity frame sequencer.
package vad_pkg;

    // Frame payload width and classification width.
    localparam int unsigned FRAME_W = 20;
    localparam int unsigned RES_W   = 2;

    typedef logic [RES_W-1:0] vad_res_t;

    // Bit positions inside the sticky error vector.
    localparam int unsigned ERR_EARLY = 0;
    localparam int unsigned ERR_TMO   = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StWaitMac,
        StHold
    } vad_state_e;

endpackage

// File: rtl/vad_step_cnt.sv
// Loadable down-counter with a zero flag; shared by the chunk, drain and
// timeout phases of the frame sequencer.
module vad_step_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vad_frame_ctrl.sv
// Frame sequencer: accepts a feature frame, loads the fetch unit, issues
// N_CHUNK chunk advances, drains the pipeline, waits for the MAC and holds
// the classification until the consumer takes it.
// Optional MAC watchdog: define VAD_FRAME_CTRL_TIMEOUT_EN.
// N_CHUNK must be at least 1.
module vad_frame_ctrl
    import vad_pkg::*;
#(
    parameter int unsigned N_CHUNK  = 5,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_valid_i,
    input  logic [FRAME_W-1:0] frame_data_i,
    output logic               frame_ready_o,
    output logic               fetch_load_o,
    output logic [FRAME_W-1:0] fetch_data_o,
    output logic               chunk_en_o,
    output logic               mac_clear_o,
    input  logic               mac_done_i,
    input  logic [RES_W-1:0]   mac_out_i,
    output logic [RES_W-1:0]   result_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic               busy_o,
    output logic [7:0]         frame_cnt_o,
    output logic [1:0]         err_o
);

    localparam int unsigned MaxNp  = (N_CHUNK > PIPE_LAT) ? N_CHUNK : PIPE_LAT;
    localparam int unsigned CntMax = (TIMEOUT > MaxNp) ? TIMEOUT : MaxNp;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    // Reload values: the counter reaches zero on the last cycle of each phase.
    localparam logic [CntW-1:0] LdChunk = CntW'(N_CHUNK - 1);
    localparam logic [CntW-1:0] LdDrain = CntW'(PIPE_LAT - 1);
    localparam logic [CntW-1:0] LdTmo   = CntW'(TIMEOUT - 1);

    vad_state_e         state_q, state_d;
    logic               frame_ready_q, fetch_load_q, chunk_en_q, mac_clear_q;
    logic               result_valid_q, busy_q;
    logic [FRAME_W-1:0] fetch_data_q;
    vad_res_t           result_q;
    logic [7:0]         frame_cnt_q;
    logic [1:0]         err_q;

    logic            cnt_load, cnt_dec, cnt_zero;
    logic [CntW-1:0] cnt_val;
    logic            accept, capture, tmo, early, done;

    vad_step_cnt #(
        .W (CntW)
    ) u_step_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state decode and step-counter control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        tmo      = 1'b0;
        early    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_valid_i && frame_ready_q) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                early    = mac_done_i;
                cnt_load = 1'b1;
                cnt_val  = LdChunk;
                state_d  = StStream;
            end
            StStream: begin
                early = mac_done_i;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (PIPE_LAT == 0) begin
                        cnt_val = LdTmo;
                        state_d = StWaitMac;
                    end else begin
                        cnt_val = LdDrain;
                        state_d = StDrain;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDrain: begin
                early = mac_done_i;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = LdTmo;
                    state_d  = StWaitMac;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWaitMac: begin
                // mac_done beats a coincident timeout.
                if (mac_done_i) begin
                    capture = 1'b1;
                    state_d = StHold;
                end
`ifdef VAD_FRAME_CTRL_TIMEOUT_EN
                else if (cnt_zero) begin
                    tmo     = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            StHold: begin
                if (result_ready_i) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath registers and outputs registered from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            frame_ready_q  <= 1'b0;
            fetch_load_q   <= 1'b0;
            mac_clear_q    <= 1'b0;
            chunk_en_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            fetch_data_q   <= '0;
            result_q       <= '0;
            frame_cnt_q    <= '0;
            err_q          <= '0;
        end else begin
            state_q        <= state_d;
            frame_ready_q  <= (state_d == StIdle);
            fetch_load_q   <= (state_d == StLoad);
            mac_clear_q    <= (state_d == StLoad);
            chunk_en_q     <= (state_d == StStream);
            result_valid_q <= (state_d == StHold);
            busy_q         <= (state_d != StIdle);
            if (accept) fetch_data_q <= frame_data_i;
            if (capture) begin
                result_q <= mac_out_i;
            end else if (tmo) begin
                result_q <= '0;
            end
            if (done) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (early) err_q[ERR_EARLY] <= 1'b1;
            if (tmo) err_q[ERR_TMO] <= 1'b1;
        end
    end

    assign frame_ready_o  = frame_ready_q;
    assign fetch_load_o   = fetch_load_q;
    assign fetch_data_o   = fetch_data_q;
    assign chunk_en_o     = chunk_en_q;
    assign mac_clear_o    = mac_clear_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_vad_frame_ctrl.sv
// Self-checking bench for vad_frame_ctrl: directed frames with a scoreboard
// of expected fetch payloads and classifications.
module tb_vad_frame_ctrl;

    localparam int unsigned N_CHUNK = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [19:0] frame_data;
    logic        frame_ready;
    logic        fetch_load;
    logic [19:0] fetch_data;
    logic        chunk_en;
    logic        mac_clear;
    logic        mac_done;
    logic [1:0]  mac_out;
    logic [1:0]  result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [1:0]  err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [19:0] fd_q[$];
    logic [1:0]  res_q[$];

    vad_frame_ctrl #(
        .N_CHUNK  (5),
        .PIPE_LAT (2),
        .TIMEOUT  (64)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_valid_i  (frame_valid),
        .frame_data_i   (frame_data),
        .frame_ready_o  (frame_ready),
        .fetch_load_o   (fetch_load),
        .fetch_data_o   (fetch_data),
        .chunk_en_o     (chunk_en),
        .mac_clear_o    (mac_clear),
        .mac_done_i     (mac_done),
        .mac_out_i      (mac_out),
        .result_o       (result),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .busy_o         (busy),
        .frame_cnt_o    (frame_cnt),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Start a frame in the current (idle) cycle and queue its expectations.
    task automatic offer(input logic [19:0] d);
        frame_valid = 1'b1;
        frame_data  = d;
        fd_q.push_back(d);
    endtask

    // Monitor: checks fetch payload, chunk run length and held results.
    int   run = 0;
    logic prev_rv = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                run     = 0;
                prev_rv = 1'b0;
            end else begin
                if (fetch_load) begin
                    if (fd_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL fetch_unexpected: got %0h, want none", fetch_data);
                    end else begin
                        chk("fetch_data", 32'(fetch_data), 32'(fd_q.pop_front()));
                    end
                    chk("mac_clear_with_load", 32'(mac_clear), 32'd1);
                    run = 0;
                end
                if (chunk_en) run++;
                if (result_valid && !prev_rv) chk("chunk_run", run, N_CHUNK);
                if (result_valid && result_ready) begin
                    if (res_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL result_unexpected: got %0h, want none", result);
                    end else begin
                        chk("result", 32'(result), 32'(res_q.pop_front()));
                    end
                end
                prev_rv = result_valid;
            end
        end
    end

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    logic [19:0] b2b_data[3] = '{20'h11111, 20'h22222, 20'h33333};
    logic [1:0]  b2b_res[3]  = '{2'b01, 2'b11, 2'b10};

    initial begin
        rst          = 1'b1;
        frame_valid  = 1'b0;
        frame_data   = '0;
        mac_done     = 1'b0;
        mac_out      = '0;
        result_ready = 1'b0;
        tick(2);
        // Reset state: all outputs low.
        chk("rst_ready_busy", {frame_ready, busy, fetch_load, mac_clear, chunk_en}, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_result", {result_valid, result, err}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", frame_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Frame 1: accept at T.
        offer(20'hA5A5A);
        res_q.push_back(2'b10);
        tick();                                   // T+1
        frame_valid = 1'b0;
        chk("load_pulse", fetch_load, 1);
        chk("load_data", fetch_data, 20'hA5A5A);
        chk("load_busy_ready", {busy, frame_ready}, 2'b10);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk($sformatf("chunk_en_T%0d", i), chunk_en, (i <= 6) ? 1 : 0);
        end
        tick();                                   // T+9
        mac_done = 1'b1;
        mac_out  = 2'b10;
        tick();                                   // T+10
        mac_done = 1'b0;
        chk("hold_valid", result_valid, 1);
        chk("hold_result", result, 2'b10);
        tick();                                   // T+11: stray mac_done in HOLD
        mac_done = 1'b1;
        mac_out  = 2'b01;
        tick();                                   // T+12
        mac_done = 1'b0;
        chk("hold_stable", result, 2'b10);
        result_ready = 1'b1;
        tick();                                   // T+13
        result_ready = 1'b0;
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_ready", frame_ready, 1);
        chk("f1_valid_low", result_valid, 0);
        chk("f1_err_clean", err, 0);

        // Three back-to-back frames with result_ready held high.
        result_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("b2b_ready_%0d", f), frame_ready, 1);
            offer(b2b_data[f]);
            res_q.push_back(b2b_res[f]);
            tick();
            frame_valid = 1'b0;
            tick(8);                              // T+9
            mac_done = 1'b1;
            mac_out  = b2b_res[f];
            tick();                               // T+10
            mac_done = 1'b0;
            chk($sformatf("b2b_valid_%0d", f), result_valid, 1);
            chk($sformatf("b2b_not_idle_%0d", f), frame_ready, 0);
            tick();                               // T+11
        end
        chk("b2b_frame_cnt", frame_cnt, 4);

        // Early mac_done during STREAM.
        offer(20'h0F0F0);
        res_q.push_back(2'b11);
        tick();
        frame_valid = 1'b0;
        tick(3);                                  // T+4
        mac_done = 1'b1;
        mac_out  = 2'b01;
        tick();                                   // T+5
        mac_done = 1'b0;
        chk("early_err", err, 2'b01);
        chk("early_still_stream", chunk_en, 1);
        tick(4);                                  // T+9
        mac_done = 1'b1;
        mac_out  = 2'b11;
        tick();                                   // T+10
        mac_done = 1'b0;
        chk("early_result", result, 2'b11);
        tick();                                   // T+11
        chk("early_frame_cnt", frame_cnt, 5);
        chk("early_err_sticky", err, 2'b01);

        // Reset in the middle of STREAM.
        offer(20'hFFFFF);
        tick();
        frame_valid = 1'b0;
        tick(3);                                  // T+4, third chunk cycle
        #1 rst = 1'b1;
        #2;
        chk("mid_rst_chunk", chunk_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt_err", {frame_cnt, err}, 0);
        chk("mid_rst_data", fetch_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", frame_ready, 1);
        offer(20'h12345);
        res_q.push_back(2'b01);
        tick();
        frame_valid = 1'b0;
        tick(8);                                  // T+9
        mac_done = 1'b1;
        mac_out  = 2'b01;
        tick();
        mac_done = 1'b0;
        tick();                                   // T+11
        chk("after_rst_frame_cnt", frame_cnt, 1);
        chk("after_rst_err", err, 0);
        result_ready = 1'b0;

`ifdef VAD_FRAME_CTRL_TIMEOUT_EN
        // No mac_done: watchdog completes the frame at WAIT_MAC entry + 64.
        offer(20'h54321);
        res_q.push_back(2'b00);
        tick();
        frame_valid = 1'b0;
        tick(71);                                 // T+72
        chk("tmo_not_yet", result_valid, 0);
        tick();                                   // T+73
        chk("tmo_valid", result_valid, 1);
        chk("tmo_result", result, 2'b00);
        chk("tmo_err", err, 2'b10);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        chk("tmo_frame_cnt", frame_cnt, 2);
`endif

        tick(2);
        chk("fd_queue_drained", fd_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
